// File: rtl/lcd_char_writer_if.sv
// Character/clear request handshake into lcd_char_writer.
// The producer drives the i_* signals and the writer answers with o_ready.
interface lcd_char_writer_if;
  logic [7:0] i_char;
  logic       i_valid;
  logic       i_clr;
  logic       o_ready;

  modport master (output i_char, output i_valid, output i_clr, input  o_ready);
  modport slave  (input  i_char, input  i_valid, input  i_clr, output o_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780-style 8-bit LCD writer: power-on init, E/RS/DATA strobing, cursor wrap.
// Build option LCD_LINE2_EN selects two-line operation (else single-line display).
module lcd_char_writer #(
  parameter int T_PWR = 3,  // all timing parameters must be >= 1
  parameter int T_E   = 1,
  parameter int T_CMD = 1,
  parameter int T_CLR = 2,
  parameter int COLS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  lcd_char_writer_if.slave bus,
  output logic             o_init_done,
  output logic             o_lcd_e,
  output logic             o_lcd_rs,
  output logic             o_lcd_rw,
  output logic [7:0]       o_lcd_data
);

  localparam int MAX_PC = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int MAX_EC = (T_E > T_CMD) ? T_E : T_CMD;
  localparam int MAX_T  = (MAX_PC > MAX_EC) ? MAX_PC : MAX_EC;
  localparam int CW     = $clog2(MAX_T + 1);
  localparam int COLW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CW-1:0]   L_PWR      = CW'(T_PWR - 1);
  localparam logic [CW-1:0]   L_E        = CW'(T_E - 1);
  localparam logic [CW-1:0]   L_CMD      = CW'(T_CMD - 1);
  localparam logic [CW-1:0]   L_CLR      = CW'(T_CLR - 1);
  localparam logic [CW-1:0]   C_SAT      = CW'(MAX_T);
  localparam logic [COLW-1:0] L_LAST_COL = COLW'(COLS - 1);

  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_LINE0   = 8'h80;
`ifdef LCD_LINE2_EN
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;
`else
  localparam logic [7:0] CMD_FUNC_SET = 8'h30;
`endif

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_init_idx;
  logic            r_init_done;
  logic [COLW-1:0] r_col;
  logic            r_wrap;
  logic            r_lcd_e;
  logic            r_lcd_rs;
  logic [7:0]      r_lcd_data;
  logic            r_ready;

  logic            w_load;
  logic            w_rs_next;
  logic [7:0]      w_data_next;
  logic            w_acc_data;
  logic            w_acc_clr;
  logic            w_init_step;
  logic            w_init_finish;
  logic            w_wrap_issue;
  logic            w_is_clr;
  logic [CW-1:0]   w_wait_lim;
  logic [7:0]      w_init_cmd;
  logic [7:0]      w_wrap_cmd;

  // The clear command needs the longer post-write wait, whether from init or a request.
  assign w_is_clr   = !r_lcd_rs && (r_lcd_data == CMD_CLEAR);
  assign w_wait_lim = w_is_clr ? L_CLR : L_CMD;

  always_comb begin
    w_init_cmd = CMD_FUNC_SET;
    case (r_init_idx)
      2'd0:    w_init_cmd = CMD_FUNC_SET;
      2'd1:    w_init_cmd = CMD_DISP_ON;
      2'd2:    w_init_cmd = CMD_CLEAR;
      default: w_init_cmd = CMD_ENTRY;
    endcase
  end

`ifdef LCD_LINE2_EN
  logic r_line;

  assign w_wrap_cmd = r_line ? CMD_LINE0 : CMD_LINE1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= 1'b0;
    end else if (w_init_finish || w_acc_clr) begin
      r_line <= 1'b0;
    end else if (w_wrap_issue) begin
      r_line <= ~r_line;
    end
  end
`else
  assign w_wrap_cmd = CMD_LINE0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PWR_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_rs_next     = r_lcd_rs;
    w_data_next   = r_lcd_data;
    w_acc_data    = 1'b0;
    w_acc_clr     = 1'b0;
    w_init_step   = 1'b0;
    w_init_finish = 1'b0;
    w_wrap_issue  = 1'b0;
    case (r_state)
      PWR_WAIT: begin
        if (r_cnt == L_PWR) begin
          w_state_next = INIT;
        end
      end
      INIT: begin
        w_load       = 1'b1;
        w_rs_next    = 1'b0;
        w_data_next  = w_init_cmd;
        w_state_next = SETUP;
      end
      IDLE: begin
        // Clear wins over a simultaneous character; the character stays pending at the source.
        if (bus.i_clr) begin
          w_acc_clr    = 1'b1;
          w_load       = 1'b1;
          w_rs_next    = 1'b0;
          w_data_next  = CMD_CLEAR;
          w_state_next = SETUP;
        end else if (bus.i_valid) begin
          w_acc_data   = 1'b1;
          w_load       = 1'b1;
          w_rs_next    = 1'b1;
          w_data_next  = bus.i_char;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        w_state_next = E_HIGH;
      end
      E_HIGH: begin
        if (r_cnt == L_E) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        w_state_next = WAIT;
      end
      WAIT: begin
        if (r_cnt == w_wait_lim) begin
          if (!r_init_done) begin
            if (r_init_idx == 2'd3) begin
              w_init_finish = 1'b1;
              w_state_next  = IDLE;
            end else begin
              w_init_step  = 1'b1;
              w_state_next = INIT;
            end
          end else if (r_wrap) begin
            // Line-end address command goes straight back to SETUP so o_ready never rises.
            w_wrap_issue = 1'b1;
            w_load       = 1'b1;
            w_rs_next    = 1'b0;
            w_data_next  = w_wrap_cmd;
            w_state_next = SETUP;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = PWR_WAIT;
      end
    endcase
  end

  // Cycle counter restarts on every state change and otherwise saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != C_SAT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_e     <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_ready     <= 1'b0;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_col       <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_lcd_e <= (w_state_next == E_HIGH);
      r_ready <= (w_state_next == IDLE);
      if (w_load) begin
        r_lcd_rs   <= w_rs_next;
        r_lcd_data <= w_data_next;
      end
      if (w_init_step) begin
        r_init_idx <= r_init_idx + 2'd1;
      end
      if (w_init_finish) begin
        r_init_done <= 1'b1;
        r_col       <= '0;
        r_wrap      <= 1'b0;
      end
      if (w_acc_clr) begin
        r_col  <= '0;
        r_wrap <= 1'b0;
      end
      if (w_acc_data) begin
        r_wrap <= (r_col == L_LAST_COL);
        r_col  <= (r_col == L_LAST_COL) ? '0 : r_col + COLW'(1);
      end
      if (w_wrap_issue) begin
        r_wrap <= 1'b0;
      end
    end
  end

  assign bus.o_ready = r_ready;
  assign o_init_done = r_init_done;
  assign o_lcd_e     = r_lcd_e;
  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer: init sequence, write timing, line wrap,
// clear priority and mid-write reset. Expected values follow LCD_LINE2_EN.
module tb_lcd_char_writer;

`ifdef LCD_LINE2_EN
  localparam logic [7:0] EXP_FSET  = 8'h38;
  localparam logic [7:0] EXP_WRAP1 = 8'hC0;
`else
  localparam logic [7:0] EXP_FSET  = 8'h30;
  localparam logic [7:0] EXP_WRAP1 = 8'h80;
`endif
  localparam logic [7:0] EXP_WRAP2 = 8'h80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       o_init_done;
  logic       o_lcd_e;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_char_writer_if bus ();

  lcd_char_writer #(
    .T_PWR(3), .T_E(1), .T_CMD(1), .T_CLR(2), .COLS(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_init_done(o_init_done),
    .o_lcd_e    (o_lcd_e),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
    bit         rdy_since;
  } pulse_t;

  pulse_t plog[$];
  logic   prev_e    = 1'b0;
  bit     rdy_seen  = 1'b0;
  int     n_checks  = 0;
  int     n_pass    = 0;

  // One line per LCD write strobe, logged with whether o_ready was seen since the previous one.
  always @(negedge clk) begin
    pulse_t p;
    if (o_lcd_e && !prev_e) begin
      p.rs = o_lcd_rs;
      p.data = o_lcd_data;
      p.cyc = cyc;
      p.rdy_since = rdy_seen;
      plog.push_back(p);
      rdy_seen = 1'b0;
      $display("lcd write rs=%0b data=%02h cycle=%0d", o_lcd_rs, o_lcd_data, cyc);
    end
    if (bus.o_ready) rdy_seen = 1'b1;
    prev_e = o_lcd_e;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int bound, input string what);
    int t;
    t = 0;
    while (!bus.o_ready && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) begin
      n_checks++;
      $display("FAIL %s_timeout: o_ready=0 after %0d cycles, required 1", what, bound);
    end
  endtask

  // Holds i_valid with a fixed character until n acceptances have happened.
  task automatic drive_held(input int n, input logic [7:0] ch);
    int acc;
    int t;
    acc = 0;
    t = 0;
    bus.i_char = ch;
    bus.i_valid = 1'b1;
    while (acc < n && t < n * 12) begin
      if (bus.o_ready) acc++;
      @(negedge clk);
      t++;
    end
    bus.i_valid = 1'b0;
    if (acc != n) begin
      n_checks++;
      $display("FAIL held_accepts: got %0d accepts, required %0d", acc, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_char = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (o_lcd_e !== 1'b0) $display("FAIL reset_e: got %b want 0", o_lcd_e); else n_pass++;
    n_checks++; if (o_lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", o_lcd_rs); else n_pass++;
    n_checks++; if (o_lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", o_lcd_rw); else n_pass++;
    n_checks++; if (o_lcd_data !== 8'h00) $display("FAIL reset_data: got %02h want 00", o_lcd_data); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.o_ready); else n_pass++;
    n_checks++; if (o_init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", o_init_done); else n_pass++;
  endtask

  task automatic test_init();
    int c0;
    int t;
    logic [7:0] exp_data [4];
    int exp_off [4];
    exp_data = '{EXP_FSET, 8'h0C, 8'h01, 8'h06};
    // 3 power-up cycles, then INIT/SETUP before each E; the gap after 0x01 is one cycle longer.
    exp_off = '{5, 10, 15, 21};
    plog.delete();
    c0 = cyc;
    rst = 1'b0;
    // Requests during init must be dropped, not queued.
    bus.i_char = 8'h41;
    bus.i_valid = 1'b1;
    bus.i_clr = 1'b1;
    t = 0;
    while (!o_init_done && t < 60) begin
      @(negedge clk);
      t++;
      if (t == 3) begin
        bus.i_valid = 1'b0;
        bus.i_clr = 1'b0;
      end
      if (bus.o_ready && !o_init_done) begin
        n_checks++;
        $display("FAIL init_ready_early: o_ready=1 at cycle %0d before o_init_done", cyc);
      end
    end
    n_checks++; if (o_init_done !== 1'b1) $display("FAIL init_done_timeout: got %b want 1", o_init_done); else n_pass++;
    n_checks++; if (cyc - c0 !== 24) $display("FAIL init_done_cycle: got +%0d want +24", cyc - c0); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b1) $display("FAIL init_ready: got %b want 1", bus.o_ready); else n_pass++;
    n_checks++; if (plog.size() !== 4) $display("FAIL init_count: got %0d pulses want 4", plog.size()); else n_pass++;
    for (int k = 0; k < 4 && k < plog.size(); k++) begin
      n_checks++;
      if (plog[k].data !== exp_data[k] || plog[k].rs !== 1'b0)
        $display("FAIL init_cmd%0d: got rs=%b data=%02h want rs=0 data=%02h", k, plog[k].rs, plog[k].data, exp_data[k]);
      else n_pass++;
      n_checks++;
      if (plog[k].cyc - c0 !== exp_off[k])
        $display("FAIL init_time%0d: got +%0d want +%0d", k, plog[k].cyc - c0, exp_off[k]);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    wait_ready(20, "single_write");
    bus.i_char = 8'h2B;
    bus.i_valid = 1'b1;
    @(negedge clk);  // k+1: SETUP
    bus.i_valid = 1'b0;
    bus.i_char = 8'h55;
    n_checks++; if (o_lcd_rs !== 1'b1) $display("FAIL wr_setup_rs: got %b want 1", o_lcd_rs); else n_pass++;
    n_checks++; if (o_lcd_data !== 8'h2B) $display("FAIL wr_setup_data: got %02h want 2b", o_lcd_data); else n_pass++;
    n_checks++; if (o_lcd_e !== 1'b0) $display("FAIL wr_setup_e: got %b want 0", o_lcd_e); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b0) $display("FAIL wr_setup_ready: got %b want 0", bus.o_ready); else n_pass++;
    @(negedge clk);  // k+2: E_HIGH
    n_checks++; if (o_lcd_e !== 1'b1) $display("FAIL wr_e_high: got %b want 1", o_lcd_e); else n_pass++;
    n_checks++; if (o_lcd_data !== 8'h2B) $display("FAIL wr_e_data: got %02h want 2b", o_lcd_data); else n_pass++;
    @(negedge clk);  // k+3: HOLD
    n_checks++; if (o_lcd_e !== 1'b0) $display("FAIL wr_hold_e: got %b want 0", o_lcd_e); else n_pass++;
    n_checks++; if (o_lcd_rs !== 1'b1) $display("FAIL wr_hold_rs: got %b want 1", o_lcd_rs); else n_pass++;
    @(negedge clk);  // k+4: WAIT
    n_checks++; if (bus.o_ready !== 1'b0) $display("FAIL wr_wait_ready: got %b want 0", bus.o_ready); else n_pass++;
    @(negedge clk);  // k+5: IDLE
    n_checks++; if (bus.o_ready !== 1'b1) $display("FAIL wr_ready_k5: got %b want 1", bus.o_ready); else n_pass++;
    n_checks++; if (o_lcd_data !== 8'h2B) $display("FAIL wr_capture: got %02h want 2b", o_lcd_data); else n_pass++;
  endtask

  task automatic test_wrap();
    int n0;
    int bad;
    wait_ready(20, "wrap_pre");
    plog.delete();
    n0 = cyc;
    bus.i_clr = 1'b1;
    @(negedge clk);
    bus.i_clr = 1'b0;
    wait_ready(20, "wrap_clr");
    n_checks++; if (cyc - n0 !== 6) $display("FAIL clr_ready_cycle: got +%0d want +6", cyc - n0); else n_pass++;
    n_checks++;
    if (plog.size() !== 1 || plog[0].rs !== 1'b0 || plog[0].data !== 8'h01)
      $display("FAIL clr_cmd: got %0d pulses, first data=%02h, want one rs=0 01", plog.size(), (plog.size() > 0) ? plog[0].data : 8'hxx);
    else n_pass++;

    plog.delete();
    drive_held(32, 8'h3D);
    wait_ready(40, "wrap_end");
    n_checks++; if (plog.size() !== 34) $display("FAIL wrap_count: got %0d pulses want 34", plog.size()); else n_pass++;
    if (plog.size() == 34) begin
      bad = 0;
      for (int k = 0; k < 34; k++)
        if (k != 16 && k != 33 && (plog[k].rs !== 1'b1 || plog[k].data !== 8'h3D)) bad++;
      n_checks++; if (bad !== 0) $display("FAIL wrap_data: got %0d bad data pulses want 0", bad); else n_pass++;
      n_checks++;
      if (plog[16].rs !== 1'b0 || plog[16].data !== EXP_WRAP1)
        $display("FAIL wrap_cmd1: got rs=%b data=%02h want rs=0 data=%02h", plog[16].rs, plog[16].data, EXP_WRAP1);
      else n_pass++;
      n_checks++; if (plog[16].rdy_since !== 1'b0) $display("FAIL wrap_ready1: got ready seen=%b want 0", plog[16].rdy_since); else n_pass++;
      n_checks++; if (plog[16].cyc - plog[15].cyc !== 4) $display("FAIL wrap_gap: got %0d want 4", plog[16].cyc - plog[15].cyc); else n_pass++;
      n_checks++; if (plog[17].rdy_since !== 1'b1) $display("FAIL wrap_resume: got ready seen=%b want 1", plog[17].rdy_since); else n_pass++;
      n_checks++;
      if (plog[33].rs !== 1'b0 || plog[33].data !== EXP_WRAP2)
        $display("FAIL wrap_cmd2: got rs=%b data=%02h want rs=0 data=%02h", plog[33].rs, plog[33].data, EXP_WRAP2);
      else n_pass++;
      n_checks++; if (plog[33].rdy_since !== 1'b0) $display("FAIL wrap_ready2: got ready seen=%b want 0", plog[33].rdy_since); else n_pass++;
    end
  endtask

  task automatic test_clr_priority();
    wait_ready(20, "clr_pri");
    plog.delete();
    bus.i_char = 8'h2D;
    bus.i_valid = 1'b1;
    bus.i_clr = 1'b1;
    @(negedge clk);
    bus.i_clr = 1'b0;
    // 0x2D is the first character after the clear, so 16 writes reach the line end.
    drive_held(16, 8'h2D);
    wait_ready(40, "clr_pri_end");
    n_checks++; if (plog.size() !== 18) $display("FAIL clrpri_count: got %0d pulses want 18", plog.size()); else n_pass++;
    if (plog.size() == 18) begin
      n_checks++;
      if (plog[0].rs !== 1'b0 || plog[0].data !== 8'h01)
        $display("FAIL clrpri_first: got rs=%b data=%02h want rs=0 data=01", plog[0].rs, plog[0].data);
      else n_pass++;
      n_checks++;
      if (plog[1].rs !== 1'b1 || plog[1].data !== 8'h2D)
        $display("FAIL clrpri_char: got rs=%b data=%02h want rs=1 data=2d", plog[1].rs, plog[1].data);
      else n_pass++;
      n_checks++; if (plog[1].cyc - plog[0].cyc !== 6) $display("FAIL clrpri_gap: got %0d want 6", plog[1].cyc - plog[0].cyc); else n_pass++;
      n_checks++;
      if (plog[17].rs !== 1'b0 || plog[17].data !== EXP_WRAP1)
        $display("FAIL clrpri_col0: got rs=%b data=%02h want rs=0 data=%02h", plog[17].rs, plog[17].data, EXP_WRAP1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int c0;
    wait_ready(20, "rst_mid");
    bus.i_char = 8'h2B;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    t = 0;
    while (!o_lcd_e && t < 8) begin
      @(negedge clk);
      t++;
    end
    n_checks++; if (o_lcd_e !== 1'b1) $display("FAIL rstmid_e_seen: got %b want 1", o_lcd_e); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (o_lcd_e !== 1'b0) $display("FAIL rstmid_e: got %b want 0", o_lcd_e); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", bus.o_ready); else n_pass++;
    n_checks++; if (o_lcd_data !== 8'h00) $display("FAIL rstmid_data: got %02h want 00", o_lcd_data); else n_pass++;
    n_checks++; if (o_init_done !== 1'b0) $display("FAIL rstmid_init_done: got %b want 0", o_init_done); else n_pass++;
    @(negedge clk);
    plog.delete();
    c0 = cyc;
    rst = 1'b0;
    t = 0;
    while (!o_init_done && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_checks++; if (cyc - c0 !== 24) $display("FAIL rstmid_done_cycle: got +%0d want +24", cyc - c0); else n_pass++;
    n_checks++; if (plog.size() !== 4) $display("FAIL rstmid_count: got %0d pulses want 4", plog.size()); else n_pass++;
    if (plog.size() > 0) begin
      n_checks++;
      if (plog[0].rs !== 1'b0 || plog[0].data !== EXP_FSET)
        $display("FAIL rstmid_first: got rs=%b data=%02h want rs=0 data=%02h", plog[0].rs, plog[0].data, EXP_FSET);
      else n_pass++;
      n_checks++; if (plog[0].cyc - c0 !== 5) $display("FAIL rstmid_first_time: got +%0d want +5", plog[0].cyc - c0); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_wrap();
    test_clr_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
